// File: rtl/led_display_pkg.sv
// Shared mode/colour constants, sequencer state type and selection helpers
// for the LED display pattern path.
package led_display_pkg;

  localparam int unsigned MODE_W   = 4;
  localparam int unsigned COLOUR_W = 3;

  localparam logic [MODE_W-1:0] MODE_OFF    = 4'd0;
  localparam logic [MODE_W-1:0] MODE_SOLID  = 4'd1;
  localparam logic [MODE_W-1:0] MODE_SCAN_H = 4'd2;
  localparam logic [MODE_W-1:0] MODE_SCAN_V = 4'd3;
  localparam logic [MODE_W-1:0] MODE_PULSE  = 4'd4;

  localparam logic [COLOUR_W-1:0] COLOUR_RESET = 3'b001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } mode_seq_state_t;

  typedef struct packed {
    logic [MODE_W-1:0]   mode;
    logic [COLOUR_W-1:0] colour;
  } pattern_sel_t;

  function automatic logic [MODE_W-1:0] next_mode(input logic [MODE_W-1:0] m);
    case (m)
      MODE_SOLID:  return MODE_SCAN_H;
      MODE_SCAN_H: return MODE_SCAN_V;
      MODE_SCAN_V: return MODE_PULSE;
      default:     return MODE_SOLID;
    endcase
  endfunction

  // Colours cycle 1..7; zero (all channels off) is never produced.
  function automatic logic [COLOUR_W-1:0] next_colour(input logic [COLOUR_W-1:0] c);
    return (c == 3'd7) ? 3'd1 : c + 3'd1;
  endfunction

  // Apply one mode step and/or one colour step; wrapping PULSE->SOLID bumps colour.
  function automatic pattern_sel_t step_sel(input pattern_sel_t s,
                                            input logic adv_mode,
                                            input logic adv_colour);
    pattern_sel_t r;
    r = s;
    if (adv_mode) begin
      r.mode = next_mode(s.mode);
      if (s.mode == MODE_PULSE) r.colour = next_colour(r.colour);
    end
    if (adv_colour) r.colour = next_colour(r.colour);
    return r;
  endfunction

endpackage

// File: rtl/led_display_tick_timer.sv
// Free-running cycle counter with enable and clear; tc_c is high while the
// count sits on its last value (CYCLES-1), after which it wraps to zero.
module led_display_tick_timer #(
  parameter int unsigned CYCLES = 2
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic en_in,
  input  logic clr_in,
  output logic tc_c
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_count <= '0;
    end else if (clr_in) begin
      r_count <= '0;
    end else if (en_in) begin
      r_count <= (r_count == LAST) ? '0 : r_count + CNT_W'(1);
    end
  end

  assign tc_c = (r_count == LAST);

endmodule

// File: rtl/led_display_mode_sequencer.sv
// Chooses mode/colour for the pattern generator; changes are staged and only
// committed on a driver frame boundary (or a timeout if the driver stalls).
module led_display_mode_sequencer
  import led_display_pkg::*;
#(
  parameter int unsigned SYS_CLK_FREQ = 100_000_000,
  parameter int unsigned SIMULATION   = 0,
  parameter int unsigned DWELL_MS     = 2000,
  parameter int unsigned SYNC_TIMEOUT = 1_000_000
) (
  input  logic                clk_in,
  input  logic                reset_in,
  input  logic                display_en_in,
  input  logic                auto_en_in,
  input  logic                btn_next_in,
  input  logic                btn_colour_in,
  input  logic                frame_sync_in,
  output logic [MODE_W-1:0]   mode_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                mode_change_out,
  output logic                pending_out
);

  localparam int unsigned DWELL_CYCLES = (SIMULATION != 0) ? 5000 : SYS_CLK_FREQ / 1000 * DWELL_MS;
  localparam int unsigned SYNC_CYCLES  = (SIMULATION != 0) ? 2000 : SYNC_TIMEOUT;

  mode_seq_state_t     r_state;
  logic [MODE_W-1:0]   r_mode;
  logic [COLOUR_W-1:0] r_colour;
  logic                r_mode_change;
  logic                r_pending;
  pattern_sel_t        r_pend;

  logic         w_dwell_tc;
  logic         w_sync_tc;
  logic         w_dwell_exp;
  logic         w_commit;
  pattern_sel_t w_run_nx;
  pattern_sel_t w_pend_nx;

  assign w_dwell_exp = (r_state == RUN) && auto_en_in && w_dwell_tc;
  assign w_commit    = (r_state == PENDING) && (frame_sync_in || w_sync_tc);

  led_display_tick_timer #(.CYCLES(DWELL_CYCLES)) u_dwell_timer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .en_in    ((r_state == RUN) && auto_en_in),
    .clr_in   (w_commit),
    .tc_c     (w_dwell_tc)
  );

  led_display_tick_timer #(.CYCLES(SYNC_CYCLES)) u_sync_timer (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .en_in    (r_state == PENDING),
    .clr_in   (w_commit),
    .tc_c     (w_sync_tc)
  );

  // Candidate selections: from the live outputs (RUN) or the staged ones (PENDING).
  // A staged OFF locks out buttons until it has been committed.
  always_comb begin
    w_run_nx  = step_sel('{mode: r_mode, colour: r_colour}, btn_next_in || w_dwell_exp, btn_colour_in);
    w_pend_nx = r_pend;
    if (!display_en_in) begin
      w_pend_nx.mode = MODE_OFF;
    end else if (r_pend.mode != MODE_OFF) begin
      w_pend_nx = step_sel(r_pend, btn_next_in, btn_colour_in);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_state       <= IDLE;
      r_mode        <= MODE_OFF;
      r_colour      <= COLOUR_RESET;
      r_mode_change <= 1'b0;
      r_pending     <= 1'b0;
      r_pend        <= '{mode: MODE_OFF, colour: COLOUR_RESET};
    end else begin
      r_mode_change <= 1'b0;
      case (r_state)
        IDLE: begin
          if (display_en_in) begin
            r_pend    <= '{mode: MODE_SOLID, colour: r_colour};
            r_pending <= 1'b1;
            r_state   <= PENDING;
          end
        end
        RUN: begin
          if (!display_en_in) begin
            r_pend    <= '{mode: MODE_OFF, colour: r_colour};
            r_pending <= 1'b1;
            r_state   <= PENDING;
          end else if (btn_next_in || btn_colour_in || w_dwell_exp) begin
            r_pend    <= w_run_nx;
            r_pending <= 1'b1;
            r_state   <= PENDING;
          end
        end
        PENDING: begin
          if (w_commit) begin
            r_mode        <= w_pend_nx.mode;
            r_colour      <= w_pend_nx.colour;
            r_mode_change <= 1'b1;
            r_pending     <= 1'b0;
            r_state       <= (w_pend_nx.mode == MODE_OFF) ? IDLE : RUN;
          end
          r_pend <= w_pend_nx;
        end
        default: begin
          r_state   <= IDLE;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

  assign mode_out        = r_mode;
  assign colour_out      = r_colour;
  assign mode_change_out = r_mode_change;
  assign pending_out     = r_pending;

endmodule
